// File: rtl/scan_seq_ctrl.sv
// scan_seq_ctrl: scan load/capture/unload sequencer with per-bit compare.
// Optional MISR signature compression is enabled by defining SCAN_SEQ_MISR_EN.
module scan_seq_ctrl #(
  parameter int CHAIN_LEN  = 15,
  parameter int CAP_CYCLES = 1
) (
  input  logic                 refclk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CHAIN_LEN-1:0] pat_si1,
  input  logic [CHAIN_LEN-1:0] pat_si2,
  input  logic [CHAIN_LEN-1:0] exp_so1,
  input  logic [CHAIN_LEN-1:0] exp_so2,
  input  logic                 so1,
  input  logic                 so2,
  output logic                 test_mode,
  output logic                 se,
  output logic                 si1,
  output logic                 si2,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [5:0]           fail_cnt,
  output logic [15:0]          signature
);
  typedef enum logic [2:0] {IDLE, LOAD, CAPTURE, UNLOAD, DONE} state_t;
  localparam logic [4:0] LAST_SHIFT = 5'(CHAIN_LEN - 1);
  localparam logic [4:0] LAST_CAP   = 5'(CAP_CYCLES - 1);
  state_t state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [CHAIN_LEN-1:0] pat1_q, pat2_q, exp1_q, exp2_q;
  logic test_mode_q, se_q, si1_q, si2_q, busy_q, done_q, pass_q;
  logic [5:0] fail_q, fail_d;
  logic [6:0] fail_sum;
  logic accept, cmp, mis1, mis2;
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    if (abort) state_d = IDLE;
    else begin
      case (state_q)
        IDLE:    if (start) begin state_d = LOAD; accept = 1'b1; end
        LOAD:    if (cnt_q == LAST_SHIFT) state_d = CAPTURE;
        CAPTURE: if (cnt_q == LAST_CAP) state_d = UNLOAD;
        UNLOAD:  if (cnt_q == LAST_SHIFT) state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
    cnt_d    = (state_d == state_q && state_q inside {LOAD, CAPTURE, UNLOAD}) ? cnt_q + 5'd1 : 5'd0;
    cmp      = (state_q == UNLOAD) && !abort;
    mis1     = cmp && (so1 != exp1_q[0]);
    mis2     = cmp && (so2 != exp2_q[0]);
    fail_sum = 7'(fail_q) + 7'(mis1) + 7'(mis2);
    fail_d   = accept ? 6'd0 : (fail_sum > 7'd63 ? 6'd63 : fail_sum[5:0]);
  end
  always_ff @(posedge refclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pat1_q      <= '0;
      pat2_q      <= '0;
      exp1_q      <= '0;
      exp2_q      <= '0;
      test_mode_q <= 1'b0;
      se_q        <= 1'b0;
      si1_q       <= 1'b0;
      si2_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      // Stimulus bit k drives si during LOAD cycle k, so bit 0 goes out on the start edge.
      pat1_q      <= accept ? pat_si1 >> 1 : pat1_q >> 1;
      pat2_q      <= accept ? pat_si2 >> 1 : pat2_q >> 1;
      si1_q       <= (state_d == LOAD) && (accept ? pat_si1[0] : pat1_q[0]);
      si2_q       <= (state_d == LOAD) && (accept ? pat_si2[0] : pat2_q[0]);
      exp1_q      <= accept ? exp_so1 : (cmp ? exp1_q >> 1 : exp1_q);
      exp2_q      <= accept ? exp_so2 : (cmp ? exp2_q >> 1 : exp2_q);
      test_mode_q <= state_d inside {LOAD, CAPTURE, UNLOAD};
      busy_q      <= state_d inside {LOAD, CAPTURE, UNLOAD};
      se_q        <= state_d inside {LOAD, UNLOAD};
      done_q      <= state_d == DONE;
      fail_q      <= fail_d;
      pass_q      <= accept ? 1'b0 : (state_d == DONE ? fail_d == 6'd0 : pass_q);
    end
  end
`ifdef SCAN_SEQ_MISR_EN
  logic [15:0] misr_q;
  // Polynomial x^16+x^12+x^3+x+1, inputs folded into the two low taps.
  always_ff @(posedge refclk or negedge reset_n) begin
    if (!reset_n) misr_q <= '0;
    else if (accept) misr_q <= '0;
    else if (cmp) misr_q <= {misr_q[14:0], 1'b0} ^ (misr_q[15] ? 16'h100B : 16'h0000) ^ {14'd0, so2, so1};
  end
  assign signature = misr_q;
`else
  assign signature = 16'h0000;
`endif
  assign test_mode = test_mode_q;
  assign se        = se_q;
  assign si1       = si1_q;
  assign si2       = si2_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_cnt  = fail_q;
endmodule

// File: tb/tb_scan_seq_ctrl.sv
// tb_scan_seq_ctrl: directed checks of scan_seq_ctrl with CHAIN_LEN=15, CAP_CYCLES=1.
module tb_scan_seq_ctrl;
  logic refclk = 1'b0, reset_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [14:0] pat_si1 = '0, pat_si2 = '0, exp_so1 = '0, exp_so2 = '0;
  logic so1_drv = 1'b0, so2_drv = 1'b0, loop = 1'b0, flip1 = 1'b0;
  logic [15:0] h1 = '0, h2 = '0;
  logic so1, so2, test_mode, se, si1, si2, busy, done, pass;
  logic [5:0] fail_cnt;
  logic [15:0] signature;
  int checks = 0, failures = 0, done_at;
  logic [39:0] se_tr, busy_tr;
  logic [14:0] si1_tr, si2_tr;
  logic [5:0] fc1;
  logic pass1, saw_done;
  logic [15:0] sig_a, sig_b;

  scan_seq_ctrl dut (
    .refclk(refclk), .reset_n(reset_n), .start(start), .abort(abort),
    .pat_si1(pat_si1), .pat_si2(pat_si2), .exp_so1(exp_so1), .exp_so2(exp_so2),
    .so1(so1), .so2(so2), .test_mode(test_mode), .se(se), .si1(si1), .si2(si2),
    .busy(busy), .done(done), .pass(pass), .fail_cnt(fail_cnt), .signature(signature)
  );

  always #5 refclk = ~refclk;

  // Loopback: scan out equals scan in from 16 cycles earlier.
  always @(posedge refclk) begin
    h1 <= {h1[14:0], si1};
    h2 <= {h2[14:0], si2};
  end
  assign so1 = loop ? h1[15] ^ flip1 : so1_drv;
  assign so2 = loop ? h2[15] : so2_drv;

  task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic run(input int pulse_at, input int flip_at);
    start = 1'b1;
    tick();
    start = 1'b0;
    done_at = 0;
    for (int n = 1; n <= 40; n++) begin
      se_tr[n-1] = se;
      busy_tr[n-1] = busy;
      if (n <= 15) begin
        si1_tr[n-1] = si1;
        si2_tr[n-1] = si2;
      end
      if (n == 1) begin
        fc1 = fail_cnt;
        pass1 = pass;
      end
      if (done === 1'b1 && done_at == 0) done_at = n;
      start = (n == pulse_at);
      flip1 = (n == flip_at);
      tick();
    end
    start = 1'b0;
    flip1 = 1'b0;
  endtask

  initial begin
    tick();
    chk("rst_ctl", {test_mode, se, si1, si2}, 0);
    chk("rst_stat", {busy, done, pass}, 0);
    chk("rst_fail", fail_cnt, 0);
    chk("rst_sig", signature, 0);
    reset_n = 1'b1;
    tick();
    chk("idle_busy", busy, 0);

    run(0, 0);
    chk("zero_done_at", done_at, 32);
    chk("zero_se", se_tr[31:0], 32'h7FFF7FFF);
    chk("zero_busy", busy_tr, 40'h007FFFFFFF);
    chk("zero_pass", pass, 1);
    chk("zero_fail", fail_cnt, 0);

    loop = 1'b1;
    pat_si1 = 15'h7FFF; exp_so1 = 15'h7FFF;
    run(0, 0);
    chk("ones_si1", si1_tr, 15'h7FFF);
    chk("ones_pass", pass, 1);
    chk("ones_fail", fail_cnt, 0);
    pat_si1 = 15'h1234; pat_si2 = 15'h0F0F; exp_so1 = 15'h1234; exp_so2 = 15'h0F0F;
    run(0, 0);
    chk("mix_si1", si1_tr, 15'h1234);
    chk("mix_si2", si2_tr, 15'h0F0F);
    chk("mix_pass_clr", pass1, 0);
    chk("mix_pass", pass, 1);
    chk("mix_fail", fail_cnt, 0);

    loop = 1'b0;
    pat_si1 = '0; pat_si2 = '0; exp_so1 = 15'h0001; exp_so2 = '0;
    run(0, 0);
    chk("one_fail", fail_cnt, 1);
    chk("one_pass", pass, 0);
    so2_drv = 1'b1;
    run(0, 0);
    chk("stuck_fail", fail_cnt, 16);
    chk("stuck_pass", pass, 0);
    repeat (3) tick();
    chk("stuck_hold", fail_cnt, 16);
    so2_drv = 1'b0; exp_so1 = 15'h4000;
    run(0, 0);
    chk("last_fc_clr", fc1, 0);
    chk("last_fail", fail_cnt, 1);
    chk("last_pass", pass, 0);

    exp_so1 = '0;
    start = 1'b1; tick(); start = 1'b0;
    repeat (6) tick();
    chk("ab_cyc7", {busy, se, test_mode}, 3'b111);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("ab_ctl", {busy, se, test_mode}, 0);
    chk("ab_fail", fail_cnt, 0);
    saw_done = 1'b0;
    for (int n = 0; n < 40; n++) begin
      saw_done |= done;
      tick();
    end
    chk("ab_no_done", saw_done, 0);
    run(0, 0);
    chk("ab_rerun_done", done_at, 32);
    chk("ab_rerun_pass", pass, 1);

    start = 1'b1; tick(); start = 1'b0;
    repeat (19) tick();
    chk("rs_unload", {busy, se}, 2'b11);
    reset_n = 1'b0;
    #1;
    chk("rs_ctl", {test_mode, se, si1, si2, busy, done, pass}, 0);
    chk("rs_fail", fail_cnt, 0);
    #2 reset_n = 1'b1;
    tick();
    run(5, 0);
    chk("busy_start_done", done_at, 32);
    run(32, 0);
    chk("done_start_ign", busy_tr[32], 0);
    chk("done_start_at", done_at, 32);
    start = 1'b1; abort = 1'b1; tick();
    start = 1'b0; abort = 1'b0;
    chk("sa_idle", {busy, se}, 0);
    tick();
    chk("sa_idle2", busy, 0);

`ifdef SCAN_SEQ_MISR_EN
    loop = 1'b1;
    pat_si1 = 15'h1234; pat_si2 = 15'h0F0F; exp_so1 = 15'h1234; exp_so2 = 15'h0F0F;
    run(0, 0);
    sig_a = signature;
    run(0, 0);
    sig_b = signature;
    chk("misr_nonzero", sig_a != 16'h0, 1);
    chk("misr_repeat", sig_b, sig_a);
    run(0, 20);
    chk("misr_flip", signature != sig_a, 1);
    loop = 1'b0;
`else
    sig_a = signature;
    chk("sig_tied", sig_a, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/scan_seq_ctrl.md
SCAN_SEQ_CTRL -- requirements
Module: scan_seq_ctrl

Interface
REQ-001 SHALL provide parameter CHAIN_LEN, default 15, meaning scan-chain length in flops per chain, legal range 2..31.
REQ-002 SHALL provide parameter CAP_CYCLES, default 1, meaning number of capture cycles with se=0, legal range 1..4.
REQ-003 SHALL use one clock, refclk; reset is asynchronous and active-low, reset_n.
REQ-004 Port: refclk, input, 1, sole clock; all flops sample on its rising edge.
REQ-005 Port: reset_n, input, 1, asynchronous active-low reset.
REQ-006 Port: start, input, 1, one-cycle pulse that begins one pattern (load, capture, unload).
REQ-007 Port: abort, input, 1, synchronous abort to IDLE.
REQ-008 Port: pat_si1 / pat_si2, input, CHAIN_LEN each, stimulus for chains 1 and 2; bit 0 is shifted first.
REQ-009 Port: exp_so1 / exp_so2, input, CHAIN_LEN each, expected unload values; bit 0 is compared first.
REQ-010 Port: so1 / so2, input, 1 each, scan outputs from the scanned design.
REQ-011 Port: test_mode / se / si1 / si2, output, 1 each, registered drive to the scanned design.
REQ-012 Port: busy / done / pass, output, 1 each, status signals.
REQ-013 Port: fail_cnt, output, 6, mismatch count for the last pattern.
REQ-014 Port: signature, output, 16, MISR result (see Configuration).

Function
REQ-015 FSM states SHALL be IDLE, LOAD, CAPTURE, UNLOAD and DONE.
REQ-016 IDLE -> LOAD on start=1 and abort=0; in IDLE, pat_* and exp_* are latched into internal shift registers on that edge.
REQ-017 LOAD SHALL last exactly CHAIN_LEN cycles, with se=1, test_mode=1 and si1/si2 = latched bit k in cycle k; LOAD then goes to CAPTURE.
REQ-018 CAPTURE SHALL last exactly CAP_CYCLES cycles, with se=0, test_mode=1 and si1=si2=0; CAPTURE then goes to UNLOAD.
REQ-019 UNLOAD SHALL last exactly CHAIN_LEN cycles, with se=1, test_mode=1 and si1=si2=0; in cycle k, so1/so2 are sampled and compared with exp bit k.
REQ-020 Each mismatching bit on either chain SHALL increment fail_cnt by 1; the count saturates at 63.
REQ-021 After the last UNLOAD cycle the FSM SHALL enter DONE for exactly 1 cycle, with done=1 and pass=(fail_cnt==0), then return to IDLE.
REQ-022 pass and fail_cnt SHALL hold their values until the next accepted start, which clears fail_cnt to 0 and pass to 0.
REQ-023 busy SHALL be 1 in LOAD, CAPTURE and UNLOAD, and 0 in IDLE and DONE.
REQ-024 start while busy=1 or in DONE SHALL be ignored.
REQ-025 abort=1 in any state SHALL force IDLE on the next edge, with se=0, test_mode=0, and no done pulse; pass and fail_cnt keep their current values.
REQ-026 When start and abort occur in the same cycle, abort wins and the FSM stays in IDLE.
REQ-027 Total latency from start to done SHALL be 2*CHAIN_LEN + CAP_CYCLES + 1 cycles.
REQ-028 The internal cycle counter SHALL be 5 bits, reload to 0 on every state entry, and never wrap within a state.

Reset
REQ-029 While reset_n=0, outputs SHALL be: test_mode=0, se=0, si1=0, si2=0, busy=0, done=0, pass=0, fail_cnt=0, signature=0, with the FSM in IDLE.
REQ-030 Reset assertion mid-pattern SHALL take effect immediately, without waiting for a clock edge.
REQ-031 After reset_n deasserts, the first accepted start is the first start pulse sampled.

Configuration
REQ-032 Macro SCAN_SEQ_MISR_EN: when defined, a 16-bit MISR (polynomial x^16+x^12+x^3+x+1) SHALL compress {so2,so1} on every UNLOAD cycle; it is cleared on accepted start, and signature presents the MISR value, stable from DONE until the next start.
REQ-033 When SCAN_SEQ_MISR_EN is undefined, signature SHALL be tied to 16'h0000 and no MISR logic is synthesised.

Verification
REQ-034 Scenario: all-zero pattern, so1/so2 held 0, exp=0 -> se high 15 cycles, low 1 cycle, high 15 cycles; done at cycle 32; pass=1; fail_cnt=0.
REQ-035 Scenario: pat_si1=15'h7FFF with a loopback model (so = si delayed 15+1 cycles), exp=15'h7FFF -> pass=1; si1=1 for all 15 LOAD cycles.
REQ-036 Scenario: exp_so1=15'h0001 with so1 held 0 -> fail_cnt=1, pass=0; so2 stuck-at-1 with exp_so2=0 -> fail_cnt=16.
REQ-037 Scenario: abort in LOAD cycle 7 -> next cycle IDLE, se=0, test_mode=0, no done; a following start runs a full pattern.
REQ-038 Scenario: reset_n pulsed low in UNLOAD -> all outputs 0 immediately; a start pulse during busy is ignored, and start+abort in IDLE stays IDLE.
REQ-039 Scenario: with SCAN_SEQ_MISR_EN defined, two runs of the same pattern give an identical non-zero signature; a single flipped so1 bit changes the signature.
